// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid,
// flush squash and a saturating head-stall counter for the hazard unit.
module pipe_stage_buf #(
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] NOP_VALUE   = '0,
    parameter int                SKID        = 1,
    parameter int                STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   i_valid,
    input  logic [DATA_W-1:0]      i_data,
    output logic                   o_ready,
    output logic                   o_valid,
    output logic [DATA_W-1:0]      o_data,
    input  logic                   i_ready,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        SKID_FULL = 2'd2
    } state_t;

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

    state_t                  r_state;
    state_t                  w_state_nx;
    logic [DATA_W-1:0]       r_main;
    logic [DATA_W-1:0]       w_skid;
    logic [STALL_CNT_W-1:0]  r_stall_cnt;
    logic                    w_in;
    logic                    w_out;
    logic                    w_load_in;
    logic                    w_load_skid;

    assign o_valid     = (r_state != EMPTY);
    assign o_data      = o_valid ? r_main : NOP_VALUE;
    assign o_stall_cnt = r_stall_cnt;

    assign w_in  = i_valid & o_ready;
    assign w_out = o_valid & i_ready;

    always_comb begin
        w_state_nx  = r_state;
        w_load_in   = 1'b0;
        w_load_skid = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in) begin
                    w_state_nx = FULL;
                    w_load_in  = 1'b1;
                end
            end
            FULL: begin
                if (w_in && w_out) begin
                    w_load_in = 1'b1;
                end else if (w_out) begin
                    w_state_nx = EMPTY;
                end else if (w_in) begin
                    w_state_nx = SKID_FULL;
                end
            end
            SKID_FULL: begin
                if (w_out) begin
                    w_state_nx  = FULL;
                    w_load_skid = 1'b1;
                end
            end
            default: w_state_nx = EMPTY;
        endcase
        // Squash wins over any handshake outcome; only reset outranks it.
        if (flush) begin
            w_state_nx  = EMPTY;
            w_load_in   = 1'b0;
            w_load_skid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Payload storage carries no reset; o_data is masked by o_valid instead.
    always_ff @(posedge clk) begin
        if (w_load_in) begin
            r_main <= i_data;
        end else if (w_load_skid) begin
            r_main <= w_skid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush || w_out) begin
            r_stall_cnt <= '0;
        end else if (o_valid && !i_ready && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] r_skid;
            logic              r_ready;

            always_ff @(posedge clk) begin
                if ((r_state == FULL) && w_in && !w_out && !flush) begin
                    r_skid <= i_data;
                end
            end

            // Registered ready: low exactly while the skid slot will be occupied.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_ready <= 1'b1;
                end else begin
                    r_ready <= (w_state_nx != SKID_FULL);
                end
            end

            assign w_skid  = r_skid;
            assign o_ready = r_ready;
        end else begin : g_noskid
            assign w_skid  = NOP_VALUE;
            assign o_ready = ~o_valid | i_ready;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: skid variant, 4-bit counter variant, no-skid variant.
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        i_valid;
    logic [31:0] i_data;
    logic        i_ready;

    logic        s_ready, s_valid;
    logic [31:0] s_data;
    logic [7:0]  s_cnt;

    logic        t_ready, t_valid;
    logic [31:0] t_data;
    logic [3:0]  t_cnt;

    logic        n_flush, n_ivalid, n_iready;
    logic [31:0] n_idata;
    logic        n_ready, n_valid;
    logic [31:0] n_data;
    logic [7:0]  n_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(32), .NOP_VALUE(32'h0), .SKID(1), .STALL_CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .i_valid(i_valid), .i_data(i_data),
        .o_ready(s_ready), .o_valid(s_valid), .o_data(s_data), .i_ready(i_ready),
        .o_stall_cnt(s_cnt)
    );

    pipe_stage_buf #(.DATA_W(32), .NOP_VALUE(32'h0), .SKID(1), .STALL_CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .flush(flush), .i_valid(i_valid), .i_data(i_data),
        .o_ready(t_ready), .o_valid(t_valid), .o_data(t_data), .i_ready(i_ready),
        .o_stall_cnt(t_cnt)
    );

    pipe_stage_buf #(.DATA_W(32), .NOP_VALUE(32'h0), .SKID(0), .STALL_CNT_W(8)) u_ns (
        .clk(clk), .rst(rst), .flush(n_flush), .i_valid(n_ivalid), .i_data(n_idata),
        .o_ready(n_ready), .o_valid(n_valid), .o_data(n_data), .i_ready(n_iready),
        .o_stall_cnt(n_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; i_valid = 1'b1; i_data = 32'hDEAD_BEEF; i_ready = 1'b0;
        n_flush = 1'b0; n_ivalid = 1'b0; n_idata = 32'h0; n_iready = 1'b0;
        #2;
        tick(); tick();
        chk("rst_valid", {31'd0, s_valid}, 32'd0);
        chk("rst_data",  s_data, 32'd0);
        chk("rst_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_cnt",   {24'd0, s_cnt}, 32'd0);
        chk("rst_ns_ready", {31'd0, n_ready}, 32'd1);

        // Streaming at full throughput
        rst = 1'b1; i_ready = 1'b1; i_valid = 1'b1; i_data = 32'h1;
        tick();
        chk("str1_data", s_data, 32'h1);
        chk("str1_valid", {31'd0, s_valid}, 32'd1);
        i_data = 32'h2;
        tick();
        chk("str2_data", s_data, 32'h2);
        chk("str2_ready", {31'd0, s_ready}, 32'd1);
        i_data = 32'h3;
        tick();
        chk("str3_data", s_data, 32'h3);
        chk("str3_valid", {31'd0, s_valid}, 32'd1);
        chk("str3_ready", {31'd0, s_ready}, 32'd1);
        i_valid = 1'b0;
        tick();
        chk("str_drain_valid", {31'd0, s_valid}, 32'd0);
        chk("str_drain_data", s_data, 32'd0);

        // Skid capture and in-order release
        i_valid = 1'b1; i_data = 32'hA;
        tick();
        chk("skA_data", s_data, 32'hA);
        i_ready = 1'b0; i_data = 32'hB;
        tick();
        chk("skB_head", s_data, 32'hA);
        chk("skB_ready", {31'd0, s_ready}, 32'd0);
        chk("skB_cnt1", {24'd0, s_cnt}, 32'd1);
        i_valid = 1'b0;
        tick();
        chk("sk_cnt2", {24'd0, s_cnt}, 32'd2);
        chk("sk_hold", s_data, 32'hA);
        i_ready = 1'b1;
        tick();
        chk("sk_relB", s_data, 32'hB);
        chk("sk_relcnt", {24'd0, s_cnt}, 32'd0);
        chk("sk_relready", {31'd0, s_ready}, 32'd1);
        tick();
        chk("sk_empty", {31'd0, s_valid}, 32'd0);

        // Counter saturation
        i_ready = 1'b0; i_valid = 1'b1; i_data = 32'h5;
        tick();
        chk("sat_start", {28'd0, t_cnt}, 32'd0);
        i_valid = 1'b0;
        repeat (15) tick();
        chk("sat_15", {28'd0, t_cnt}, 32'd15);
        repeat (5) tick();
        chk("sat_hold", {28'd0, t_cnt}, 32'd15);
        chk("sat_wide20", {24'd0, s_cnt}, 32'd20);
        chk("sat_data", t_data, 32'h5);
        i_ready = 1'b1;
        tick();
        chk("sat_clear", {28'd0, t_cnt}, 32'd0);

        // Flush out of SKID_FULL with a live offer
        i_ready = 1'b0; i_valid = 1'b1; i_data = 32'h7;
        tick();
        i_data = 32'h8;
        tick();
        chk("fl_pre_ready", {31'd0, s_ready}, 32'd0);
        i_data = 32'hC; flush = 1'b1;
        tick();
        chk("fl_valid", {31'd0, s_valid}, 32'd0);
        chk("fl_data", s_data, 32'd0);
        chk("fl_cnt", {24'd0, s_cnt}, 32'd0);
        chk("fl_ready", {31'd0, s_ready}, 32'd1);
        flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        tick();
        chk("fl_noC_valid", {31'd0, s_valid}, 32'd0);
        tick();
        chk("fl_noC_data", s_data, 32'd0);

        // Single-entry variant with combinational ready
        n_ivalid = 1'b1; n_idata = 32'h11; n_iready = 1'b0;
        tick();
        chk("ns_head", n_data, 32'h11);
        chk("ns_ready_low", {31'd0, n_ready}, 32'd0);
        n_iready = 1'b1;
        #1;
        chk("ns_ready_comb", {31'd0, n_ready}, 32'd1);
        n_idata = 32'h22;
        tick();
        chk("ns_replace", n_data, 32'h22);
        chk("ns_valid", {31'd0, n_valid}, 32'd1);
        n_iready = 1'b0; n_idata = 32'h33;
        #1;
        chk("ns_ready_drop", {31'd0, n_ready}, 32'd0);
        tick();
        chk("ns_hold", n_data, 32'h22);
        chk("ns_cnt", {24'd0, n_cnt}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised inter-stage pipeline register for the 5-stage core. It is the generalised replacement for the fixed-width fetch/decode, decode/ALU, ALU/mem and mem/WB buffers.
- Carries a DATA_W-bit payload with a valid/ready handshake, an optional 2-entry skid path, a flush input for branch/interrupt squash, and a saturating stall counter for the hazard unit.
- Sits between any two stages and is instantiated once per stage boundary.

Parameters:
- DATA_W, 32, payload width in bits (packed WB/Mem/Ex/pc/Rdst/immd/data fields).
- NOP_VALUE, 0, value driven on o_data whenever o_valid=0 (bubble = all-zero control signals).
- SKID, 1, 1 = registered o_ready with 2-entry skid storage; 0 = single entry with combinational o_ready.
- STALL_CNT_W, 8, width of the stall counter.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous, active-low reset.
- flush, input, 1, squash all held entries this cycle.
- i_valid, input, 1, upstream stage presents i_data.
- i_data, input, DATA_W, upstream payload.
- o_ready, output, 1, buffer accepts i_data this cycle.
- o_valid, output, 1, o_data holds a live entry.
- o_data, output, DATA_W, head entry payload, or NOP_VALUE when o_valid=0.
- i_ready, input, 1, downstream stage consumes o_data this cycle.
- o_stall_cnt, output, STALL_CNT_W, consecutive cycles the head was blocked.

Behaviour:
- Transfer rules:
  - In: upstream transfer when i_valid & o_ready at the clock edge.
  - Out: downstream transfer when o_valid & i_ready.
- Reset (rst=0 at a clock edge):
  - State EMPTY; o_valid=0; o_data=NOP_VALUE; o_stall_cnt=0.
  - o_ready=1 from the first cycle after reset.
  - Reset mid-transfer discards all entries with no partial update.
- Storage: main register (head) plus skid register (present only when SKID=1).
- States:
  - EMPTY: o_valid=0. In-transfer loads main and moves to FULL.
  - FULL: o_valid=1.
    - In and out together: main <= i_data, stay FULL.
    - Out only: move to EMPTY.
    - In only: SKID=1 → skid <= i_data, move to SKID_FULL. SKID=0 → not reachable, because o_ready=0.
    - Neither: hold.
  - SKID_FULL (SKID=1 only): o_valid=1, o_ready=0. Out-transfer: main <= skid, move to FULL. Otherwise hold.
- o_ready:
  - SKID=1: registered, o_ready = (next state != SKID_FULL).
  - SKID=0: o_ready = ~o_valid | i_ready, combinational.
- Latency: 1 cycle from in-transfer to o_valid. Full throughput (one transfer per cycle) when i_ready is held high.
- Ordering: strict FIFO. Entries are never dropped or duplicated except by flush or reset.
- flush: priority over everything except rst.
  - Next state EMPTY; o_valid=0; o_data=NOP_VALUE; o_stall_cnt=0.
  - An i_data offered in the flush cycle is discarded, even if o_ready=1.
  - An out-transfer in the flush cycle still counts as consumed; downstream sees it.
- o_stall_cnt:
  - Increments each cycle with o_valid & ~i_ready and saturates at all-ones.
  - Clears on an out-transfer, flush or reset.
- Holding: o_data is stable while o_valid & ~i_ready. No combinational path from i_data to o_data.

Test Plan:
- Reset: hold rst=0 for 2 cycles with i_valid=1, i_data=32'hDEAD_BEEF → o_valid=0, o_data=0, o_ready=1, o_stall_cnt=0.
- Streaming: i_ready=1; send 32'h1, 32'h2, 32'h3 on back-to-back cycles → o_data shows 1, 2, 3 one cycle later each, o_valid continuously 1, o_ready never drops.
- Skid (SKID=1): drop i_ready while 32'hA is the head and 32'hB is offered → B captured in skid, o_ready=0 next cycle. Raise i_ready → A out, then B, with no loss. o_stall_cnt counts 1, 2, … during the stall, then clears to 0.
- Saturation (STALL_CNT_W=4): hold i_ready=0 for 20 cycles with one entry → o_stall_cnt reaches 15 and stays 15.
- Flush: in SKID_FULL with i_valid=1 and i_data=32'hC, assert flush for 1 cycle → next cycle o_valid=0, o_data=NOP_VALUE, o_stall_cnt=0. Value C never appears.
- SKID=0 variant: i_ready=0 with one entry → o_ready=0 in the same cycle. Raising i_ready with i_valid=1 → simultaneous in and out, head replaced, state stays FULL.
